// File: rtl/systolic_array.sv
// Output-stationary SIZE x SIZE unsigned systolic matrix multiplier (C = A x B) with pre-skewed lane inputs.
// Latency: C complete and done=1 on edge 3*SIZE-2 after reset release; C is combinational from the accumulators.
// No backpressure: lanes are consumed every edge until done, then ignored; SYSTOLIC_SAT_EN selects saturating accumulators.
module systolic_array #(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SIZE*DATA_WIDTH-1:0]       A,
    input  logic [SIZE*DATA_WIDTH-1:0]       B,
    output logic                             done,
    output logic [SIZE*SIZE*2*DATA_WIDTH-1:0] C
);

    localparam int AW   = 2 * DATA_WIDTH;
    localparam int LAST = 3 * SIZE - 2;
    localparam int CW   = $clog2(LAST + 1);

    // Operand pipelines only exist where a neighbour consumes them:
    // a moves right (no register after the last column), b moves down
    // (no register after the last row).
    logic [DATA_WIDTH-1:0] a_q     [SIZE][SIZE-1];
    logic [DATA_WIDTH-1:0] b_q     [SIZE-1][SIZE];
    logic [DATA_WIDTH-1:0] a_in    [SIZE][SIZE];
    logic [DATA_WIDTH-1:0] b_in    [SIZE][SIZE];
    logic [AW-1:0]         acc     [SIZE][SIZE];
    logic [AW-1:0]         acc_nxt [SIZE][SIZE];
    logic [CW-1:0]         cnt;

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
            logic [AW-1:0] prod;

            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = A[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_a_int
                assign a_in[gi][gj] = a_q[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = B[gj*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_b_int
                assign b_in[gi][gj] = b_q[gi-1][gj];
            end

            assign prod = AW'(a_in[gi][gj]) * AW'(b_in[gi][gj]);

`ifdef SYSTOLIC_SAT_EN
            // One extra bit catches the carry out; clamp to all-ones instead of wrapping.
            logic [AW:0] sum;
            assign sum = {1'b0, acc[gi][gj]} + {1'b0, prod};
            assign acc_nxt[gi][gj] = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
`else
            assign acc_nxt[gi][gj] = acc[gi][gj] + prod;
`endif

            assign C[(gi*SIZE+gj)*AW +: AW] = acc[gi][gj];
        end
    end

    // Edge counter and done flag; done freezes the counter at LAST and all PE state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!done) begin
            cnt  <= cnt + 1'b1;
            done <= (cnt == CW'(LAST - 1));
        end
    end

    // PE array: accumulate in place and shift operands right/down while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    acc[i][j] <= '0;
                end
            end
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE - 1; j++) begin
                    a_q[i][j] <= '0;
                end
            end
            for (int i = 0; i < SIZE - 1; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    b_q[i][j] <= '0;
                end
            end
        end else if (!done) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    acc[i][j] <= acc_nxt[i][j];
                end
            end
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE - 1; j++) begin
                    a_q[i][j] <= a_in[i][j];
                end
            end
            for (int i = 0; i < SIZE - 1; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    b_q[i][j] <= b_in[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboarded bench for systolic_array: matrix-level reference model, skewed lane driver, done-triggered monitor.
// Expected products are queued at stimulus time and popped when done rises.
// Build with SYSTOLIC_SAT_EN defined to check the saturating variant.
module tb_systolic_array;

    localparam int S    = 3;
    localparam int W    = 10;
    localparam int AW   = 2 * W;
    localparam int LAST = 3 * S - 2;
    localparam int CB   = S * S * AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [S*W-1:0] A  = '0;
    logic [S*W-1:0] B  = '0;
    logic          done;
    logic [CB-1:0] C;

    systolic_array #(.SIZE(S), .DATA_WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .done (done),
        .C    (C)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CB-1:0] c;
        int            edge_n;
        int            id;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    int          edge_cnt = 0;
    int unsigned ma[S][S];
    int unsigned mb[S][S];

    // Edges since reset release, numbered from 1.
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    // Reference: plain matrix product, then wrap or clamp to 2*W bits.
    function automatic logic [CB-1:0] ref_product();
        logic [CB-1:0] r;
        longint unsigned sum;
        r = '0;
        for (int i = 0; i < S; i++) begin
            for (int j = 0; j < S; j++) begin
                sum = 0;
                for (int k = 0; k < S; k++) sum += longint'(ma[i][k]) * longint'(mb[k][j]);
`ifdef SYSTOLIC_SAT_EN
                if (sum > (64'd1 << AW) - 1) sum = (64'd1 << AW) - 1;
`else
                sum = sum % (64'd1 << AW);
`endif
                r[(i*S+j)*AW +: AW] = AW'(sum);
            end
        end
        return r;
    endfunction

    // A lane i carries A[i][k] at edge i+k+1, zero otherwise.
    function automatic logic [S*W-1:0] a_lanes(input int e);
        logic [S*W-1:0] v;
        v = '0;
        for (int i = 0; i < S; i++) begin
            int k;
            k = e - i - 1;
            if (k >= 0 && k < S) v[i*W +: W] = W'(ma[i][k]);
        end
        return v;
    endfunction

    // B lane j carries B[k][j] at edge j+k+1, zero otherwise.
    function automatic logic [S*W-1:0] b_lanes(input int e);
        logic [S*W-1:0] v;
        v = '0;
        for (int j = 0; j < S; j++) begin
            int k;
            k = e - j - 1;
            if (k >= 0 && k < S) v[j*W +: W] = W'(mb[k][j]);
        end
        return v;
    endfunction

    task automatic chk_c(input string name, input logic [CB-1:0] act, input logic [CB-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: C=%h expected %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: each rising done pops one expectation and checks C and arrival edge.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && prev_done !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk_int("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk_c($sformatf("product_t%0d", e.id), C, e.c);
                    chk_int($sformatf("done_edge_t%0d", e.id), edge_cnt, e.edge_n);
                end
            end
            prev_done = done;
        end
    end

    // Reset, then drive the skewed schedule; optionally abort with reset after edge abort_at.
    task automatic run(input bit push, input int abort_at, input int id);
        rst = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (push) sb_q.push_back('{c: ref_product(), edge_n: LAST, id: id});
        for (int e = 1; e <= LAST + 2; e++) begin
            A = a_lanes(e);
            B = b_lanes(e);
            if (e == 1) rst = 1'b1;
            @(posedge clk);
            if (e == abort_at) begin
                #1 rst = 1'b0;
                #1;
                chk_c($sformatf("abort_c_t%0d", id), C, '0);
                chk_int($sformatf("abort_done_t%0d", id), int'(done), 0);
                A = '0;
                B = '0;
                return;
            end
            @(negedge clk);
        end
        A = '0;
        B = '0;
        for (int t = 0; t < 5 && sb_q.size() != 0; t++) @(negedge clk);
        chk_int($sformatf("drain_t%0d", id), sb_q.size(), 0);
    endtask

    task automatic load_t2();
        ma = '{'{4, 5, 7}, '{16, 5, 15}, '{2, 8, 4}};
        mb = '{'{6, 12, 2}, '{19, 7, 16}, '{18, 2, 18}};
    endtask

    initial begin
        logic [CB-1:0] held;

        // T1: reset state, then an all-zero run
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_c("reset_c", C, '0);
        chk_int("reset_done", int'(done), 0);
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end
        run(1'b1, 0, 1);

        // T2: reference product
        load_t2();
        run(1'b1, 0, 2);

        // T3: results hold against random lane traffic
        held = ref_product();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            A = (S*W)'($urandom);
            B = (S*W)'($urandom);
            @(posedge clk);
            #1;
            chk_c("hold_c", C, held);
            chk_int("hold_done", int'(done), 1);
        end
        A = '0;
        B = '0;

        // T4: all-max operands (wrap or saturate)
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                ma[i][j] = 1023;
                mb[i][j] = 1023;
            end
        run(1'b1, 0, 4);

        // T5: reset at edge 4, then a clean rerun
        load_t2();
        run(1'b0, 4, 5);
        run(1'b1, 0, 5);

        // T6: identity times B
        ma = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
        mb = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        run(1'b1, 0, 6);

        // Random matrices across the full operand range
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < S; i++)
                for (int j = 0; j < S; j++) begin
                    ma[i][j] = $urandom_range(0, 1023);
                    mb[i][j] = $urandom_range(0, 1023);
                end
            run(1'b1, 0, 10 + r);
        end

        chk_int("queue_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
